// File: rtl/fft_r2_butterfly_pipe.sv
// Radix-2 DIT butterfly: X = A + W*B, Y = A - W*B on complex fixed-point samples.
// Three register stages (products, rounded complex combine, add/sub) with one global stall.
module fft_r2_butterfly_pipe #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  localparam int OUT_W = DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  x_re,
  output logic signed [OUT_W-1:0]  x_im,
  output logic signed [OUT_W-1:0]  y_re,
  output logic signed [OUT_W-1:0]  y_im
);

  localparam int PROD_W = DATA_W + TW_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic signed [SUM_W-1:0] RND_BIAS = SUM_W'(1) << (TW_W - 2);

  // Q1.(TW_W-1) product back to sample scale, rounding half toward +inf.
  // Range analysis guarantees the top bits dropped here are pure sign copies.
  function automatic logic signed [OUT_W-1:0] round_half_up(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] biased;
    logic signed [SUM_W-1:0] shifted;
    biased  = v + RND_BIAS;
    shifted = biased >>> (TW_W - 1);
    return shifted[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] sext_a(input logic signed [DATA_W-1:0] v);
    return $signed({{(OUT_W - DATA_W){v[DATA_W-1]}}, v});
  endfunction

  logic stall;

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = rst_n & ~stall;

  // Stage p0: partial products and A
  logic                     vld_p0;
  logic signed [PROD_W-1:0] rr_p0, ii_p0, ri_p0, ir_p0;
  logic signed [DATA_W-1:0] a_re_p0, a_im_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      rr_p0   <= '0;
      ii_p0   <= '0;
      ri_p0   <= '0;
      ir_p0   <= '0;
      a_re_p0 <= '0;
      a_im_p0 <= '0;
    end else if (!stall) begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        rr_p0   <= b_re * w_re;
        ii_p0   <= b_im * w_im;
        ri_p0   <= b_re * w_im;
        ir_p0   <= b_im * w_re;
        a_re_p0 <= a_re;
        a_im_p0 <= a_im;
      end
    end
  end

  // Stage p1: complex combine and rounding to W*B
  logic signed [SUM_W-1:0]  pr_sum, pi_sum;
  logic                     vld_p1;
  logic signed [OUT_W-1:0]  wb_re_p1, wb_im_p1;
  logic signed [DATA_W-1:0] a_re_p1, a_im_p1;

  assign pr_sum = $signed({rr_p0[PROD_W-1], rr_p0}) - $signed({ii_p0[PROD_W-1], ii_p0});
  assign pi_sum = $signed({ri_p0[PROD_W-1], ri_p0}) + $signed({ir_p0[PROD_W-1], ir_p0});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      wb_re_p1 <= '0;
      wb_im_p1 <= '0;
      a_re_p1  <= '0;
      a_im_p1  <= '0;
    end else if (!stall) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        wb_re_p1 <= round_half_up(pr_sum);
        wb_im_p1 <= round_half_up(pi_sum);
        a_re_p1  <= a_re_p0;
        a_im_p1  <= a_im_p0;
      end
    end
  end

  // Stage p2: butterfly add/subtract into the output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      x_re      <= '0;
      x_im      <= '0;
      y_re      <= '0;
      y_im      <= '0;
    end else if (!stall) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        x_re <= sext_a(a_re_p1) + wb_re_p1;
        x_im <= sext_a(a_im_p1) + wb_im_p1;
        y_re <= sext_a(a_re_p1) - wb_re_p1;
        y_im <= sext_a(a_im_p1) - wb_im_p1;
      end
    end
  end

endmodule

// File: tb/tb_fft_r2_butterfly_pipe.sv
// Bench for fft_r2_butterfly_pipe: directed corners, streams, stalls, random traffic and mid-run reset.
module tb_fft_r2_butterfly_pipe;

  localparam int DATA_W = 16;
  localparam int TW_W   = 16;
  localparam int OUT_W  = DATA_W + 2;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [OUT_W-1:0]  x_re, x_im, y_re, y_im;

  typedef struct packed {
    logic signed [OUT_W-1:0] xr;
    logic signed [OUT_W-1:0] xi;
    logic signed [OUT_W-1:0] yr;
    logic signed [OUT_W-1:0] yi;
  } beat_t;

  beat_t exp_q[$];
  beat_t cap_q[$];
  int    acc_cyc[$];
  int    cap_cyc[$];
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;
  int    waits_seen = 0;

  fft_r2_butterfly_pipe #(.DATA_W(DATA_W), .TW_W(TW_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer with the cycle it occurred in.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      cap_q.push_back(beat_t'{x_re, x_im, y_re, y_im});
      cap_cyc.push_back(cyc);
    end
  end

  // Reference: exact complex product scaled by 2^-(TW_W-1), rounded half up via floor.
  function automatic beat_t model(input int ar, ai, br, bi, wr, wi);
    longint pr, pi;
    int     wbr, wbi;
    beat_t  m;
    pr  = longint'(br) * wr - longint'(bi) * wi;
    pi  = longint'(br) * wi + longint'(bi) * wr;
    wbr = $rtoi($floor((real'(pr) + 16384.0) / 32768.0));
    wbi = $rtoi($floor((real'(pi) + 16384.0) / 32768.0));
    m.xr = OUT_W'(ar + wbr);
    m.xi = OUT_W'(ai + wbi);
    m.yr = OUT_W'(ar - wbr);
    m.yi = OUT_W'(ai - wbi);
    return m;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic flush_queues();
    exp_q.delete(); cap_q.delete(); acc_cyc.delete(); cap_cyc.delete();
  endtask

  // Present one beat, hold it until accepted, log the expected result.
  task automatic send(input int ar, ai, br, bi, wr, wi);
    int n;
    n = 0;
    a_re = DATA_W'(ar); a_im = DATA_W'(ai);
    b_re = DATA_W'(br); b_im = DATA_W'(bi);
    w_re = TW_W'(wr);   w_im = TW_W'(wi);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    waits_seen += n;
    if (n >= 200) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end else begin
      exp_q.push_back(model(ar, ai, br, bi, wr, wi));
      acc_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    idle(3);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl in_ready=%0b out_valid=%0b required 0/0", in_ready, out_valid);
    end
    vectors++;
    if ({x_re, x_im, y_re, y_im} !== '0) begin
      miscompares++;
      $display("FAIL reset_data x=(%0d,%0d) y=(%0d,%0d) required all 0", x_re, x_im, y_re, y_im);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release in_ready=%0b required=1", in_ready);
    end
    idle(1);
  endtask

  task automatic test_directed();
    int    tv[5][6] = '{'{100, 0, 50, 0, 32767, 0},
                        '{100, 0, 50, 0, 0, -32768},
                        '{32767, 0, 32767, 0, 32767, 0},
                        '{-32768, 0, -32768, 0, -32768, 0},
                        '{-32768, -32768, -32768, 32767, -32768, 32767}};
    int    sx[4][4] = '{'{150, 0, 50, 0}, '{100, -50, 100, 50},
                        '{65533, 0, 1, 0}, '{0, 0, -65536, 0}};
    beat_t e;
    flush_queues();
    for (int i = 0; i < 5; i++) begin
      send(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4], tv[i][5]);
      idle(6);
    end
    vectors++;
    if (cap_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL directed_count got %0d beats required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      vectors++;
      if (cap_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL directed_data[%0d] got x=(%0d,%0d) y=(%0d,%0d) required x=(%0d,%0d) y=(%0d,%0d)",
                 i, cap_q[i].xr, cap_q[i].xi, cap_q[i].yr, cap_q[i].yi,
                 exp_q[i].xr, exp_q[i].xi, exp_q[i].yr, exp_q[i].yi);
      end
      vectors++;
      if (cap_cyc[i] - acc_cyc[i] !== 3) begin
        miscompares++;
        $display("FAIL directed_latency[%0d] got %0d cycles required 3", i, cap_cyc[i] - acc_cyc[i]);
      end
      if (i < 4) begin
        e = beat_t'{OUT_W'(sx[i][0]), OUT_W'(sx[i][1]), OUT_W'(sx[i][2]), OUT_W'(sx[i][3])};
        vectors++;
        if (cap_q[i] !== e) begin
          miscompares++;
          $display("FAIL directed_const[%0d] got x=(%0d,%0d) y=(%0d,%0d) required x=(%0d,%0d) y=(%0d,%0d)",
                   i, cap_q[i].xr, cap_q[i].xi, cap_q[i].yr, cap_q[i].yi, e.xr, e.xi, e.yr, e.yi);
        end
      end
    end
    flush_queues();
  endtask

  task automatic test_back_to_back();
    flush_queues();
    waits_seen = 0;
    for (int k = 1; k <= 8; k++) send(0, 0, k, 0, 32767, 0);
    idle(6);
    vectors++;
    if (waits_seen !== 0) begin
      miscompares++;
      $display("FAIL stream_in_ready got %0d stalled cycles required 0", waits_seen);
    end
    vectors++;
    if (cap_q.size() !== 8) begin
      miscompares++;
      $display("FAIL stream_count got %0d beats required 8", cap_q.size());
    end
    for (int i = 0; i < 8 && i < cap_q.size(); i++) begin
      vectors++;
      if (cap_q[i] !== exp_q[i] || cap_q[i].xr !== OUT_W'(i + 1)) begin
        miscompares++;
        $display("FAIL stream_data[%0d] got x_re=%0d required %0d", i, cap_q[i].xr, exp_q[i].xr);
      end
      vectors++;
      if (cap_cyc[i] !== cap_cyc[0] + i) begin
        miscompares++;
        $display("FAIL stream_gap[%0d] got cycle %0d required %0d", i, cap_cyc[i], cap_cyc[0] + i);
      end
    end
    flush_queues();
  endtask

  task automatic test_stall();
    flush_queues();
    fork
      begin
        for (int k = 1; k <= 8; k++) send(0, 0, k, 0, 32767, 0);
      end
      begin
        idle(5);
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          vectors++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_ctrl in_ready=%0b out_valid=%0b required 0/1", in_ready, out_valid);
          end
          vectors++;
          if (x_re !== exp_q[2].xr) begin
            miscompares++;
            $display("FAIL stall_hold x_re=%0d required %0d", x_re, exp_q[2].xr);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(8);
    vectors++;
    if (cap_q.size() !== 8) begin
      miscompares++;
      $display("FAIL stall_count got %0d beats required 8", cap_q.size());
    end
    for (int i = 0; i < 8 && i < cap_q.size(); i++) begin
      vectors++;
      if (cap_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL stall_data[%0d] got x_re=%0d required %0d", i, cap_q[i].xr, exp_q[i].xr);
      end
    end
    flush_queues();
  endtask

  task automatic test_random();
    bit done;
    int n;
    done = 1'b0;
    flush_queues();
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
          idle(int'($urandom_range(0, 2)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          idle(1);
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (cap_q.size() < exp_q.size() && n < 500) begin idle(1); n++; end
    idle(5);
    vectors++;
    if (cap_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL random_count got %0d beats required %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      vectors++;
      if (cap_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL random_data[%0d] got x=(%0d,%0d) y=(%0d,%0d) required x=(%0d,%0d) y=(%0d,%0d)",
                 i, cap_q[i].xr, cap_q[i].xi, cap_q[i].yr, cap_q[i].yi,
                 exp_q[i].xr, exp_q[i].xi, exp_q[i].yr, exp_q[i].yi);
      end
    end
    flush_queues();
  endtask

  task automatic test_midreset();
    flush_queues();
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      a_re = DATA_W'(10 * k); a_im = '0; b_re = DATA_W'(k); b_im = '0;
      w_re = TW_W'(32767); w_im = '0;
      in_valid = 1'b1;
      idle(1);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_in_ready_low in_ready=%0b required=0", in_ready);
    end
    idle(1);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || {x_re, x_im, y_re, y_im} !== '0) begin
      miscompares++;
      $display("FAIL midreset_clear out_valid=%0b x=(%0d,%0d) y=(%0d,%0d) required 0", out_valid, x_re, x_im, y_re, y_im);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_in_ready in_ready=%0b required=1", in_ready);
    end
    out_ready = 1'b1;
    idle(10);
    vectors++;
    if (cap_q.size() !== 0) begin
      miscompares++;
      $display("FAIL midreset_stale got %0d beats required 0", cap_q.size());
    end
    flush_queues();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
